// File: rtl/sram_arb_pkg.sv
// Shared types and the round-robin search used by the SRAM arbiter and bus arbiters.
package sram_arb_pkg;

  localparam int NumReqMax = 4;

  typedef logic [$clog2(NumReqMax)-1:0] req_idx_t;

  typedef struct packed {
    logic     vld;
    req_idx_t idx;
  } pick_t;

  // First requester at or after ptr, wrapping modulo num; ptr must be < num.
  function automatic pick_t rr_pick(input logic [NumReqMax-1:0] req, input req_idx_t ptr,
                                    input int num);
    pick_t res;
    int    j;
    res = '0;
    for (int k = 0; k < NumReqMax; k++) begin
      j = int'(ptr) + k;
      if (j >= num) j = j - num;
      if (k < num && !res.vld && req[j]) begin
        res.vld = 1'b1;
        res.idx = req_idx_t'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Combinational round-robin picker: zero latency, no state; vld low when nothing requests.
module sram_arb_rr_pick
  import sram_arb_pkg::*;
#(
  parameter int NumReq = 2
) (
  input  logic [NumReq-1:0] req,
  input  req_idx_t          ptr,
  output logic              vld,
  output req_idx_t          idx
);

  logic [NumReqMax-1:0] req_pad;
  pick_t                pick;

  always_comb begin
    req_pad             = '0;
    req_pad[NumReq-1:0] = req;
    pick                = rr_pick(req_pad, ptr, NumReq);
    vld                 = pick.vld;
    idx                 = pick.idx;
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin share of one single-port SRAM macro; grant same cycle, read data one cycle later.
// Losers simply see gnt_o=0 and hold their request until granted.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NumReq    = 2,
  parameter int SramAw    = 12,
  parameter int SramDw    = 32,
  parameter bit FixedPrio = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0]        we_i,
  input  logic [NumReq*SramAw-1:0] addr_i,
  input  logic [NumReq*SramDw-1:0] wdata_i,
  input  logic [NumReq*SramDw-1:0] wmask_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [SramDw-1:0]        rdata_o,
  output logic                     mem_en_o,
  output logic [SramDw-1:0]        mem_we_o,
  output logic [SramAw-1:0]        mem_addr_o,
  output logic [SramDw-1:0]        mem_wdata_o,
  input  logic [SramDw-1:0]        mem_rdata_i
);

  req_idx_t             ptr_q, rv_idx_q, pick_ptr, win;
  logic                 rv_pend_q, pick_vld, grant, rd_grant;
  logic [NumReqMax-1:0] we_pad;

  assign pick_ptr = FixedPrio ? '0 : ptr_q;

  sram_arb_rr_pick #(.NumReq(NumReq)) u_pick (
    .req (req_i),
    .ptr (pick_ptr),
    .vld (pick_vld),
    .idx (win)
  );

  // Reset masks the grant so the macro is never enabled while in reset.
  assign grant    = pick_vld & rst_ni;
  assign mem_en_o = grant;

  always_comb begin
    we_pad             = '0;
    we_pad[NumReq-1:0] = we_i;
    gnt_o              = '0;
    mem_addr_o         = '0;
    mem_wdata_o        = '0;
    mem_we_o           = '0;
    if (grant) begin
      gnt_o       = NumReq'(1) << win;
      mem_addr_o  = addr_i[win*SramAw +: SramAw];
      mem_wdata_o = wdata_i[win*SramDw +: SramDw];
      if (we_pad[win]) mem_we_o = wmask_i[win*SramDw +: SramDw];
    end
  end

  // An all-zero write mask leaves the macro in read mode, so it returns data like a read.
  assign rd_grant = grant & ~|mem_we_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      rv_pend_q <= 1'b0;
      rv_idx_q  <= '0;
    end else begin
      rv_pend_q <= rd_grant;
      if (rd_grant) rv_idx_q <= win;
      if (grant) ptr_q <= (win == req_idx_t'(NumReq - 1)) ? '0 : win + 1'b1;
    end
  end

  assign rvalid_o = rv_pend_q ? (NumReq'(1) << rv_idx_q) : '0;
  assign rdata_o  = rv_pend_q ? mem_rdata_i : '0;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: round-robin, fixed-priority and three-requester instances.
module tb_sram_rr_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // ---------------- instance A: NumReq=2, round-robin, with macro model
  logic [1:0]      a_req, a_we, a_gnt, a_rvalid;
  logic [2*AW-1:0] a_addr;
  logic [2*DW-1:0] a_wdata, a_wmask;
  logic [DW-1:0]   a_rdata, a_mwe, a_mwd, a_mrd;
  logic [AW-1:0]   a_maddr;
  logic            a_en;

  sram_rr_arbiter #(.NumReq(2), .SramAw(AW), .SramDw(DW), .FixedPrio(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
    .wdata_i(a_wdata), .wmask_i(a_wmask), .gnt_o(a_gnt), .rvalid_o(a_rvalid),
    .rdata_o(a_rdata), .mem_en_o(a_en), .mem_we_o(a_mwe), .mem_addr_o(a_maddr),
    .mem_wdata_o(a_mwd), .mem_rdata_i(a_mrd)
  );

  logic [DW-1:0] mac     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  // Write-first single-port macro driven by the DUT's memory pins.
  always @(posedge clk) begin
    if (a_en) begin
      mac[a_maddr] <= (mac[a_maddr] & ~a_mwe) | (a_mwd & a_mwe);
      a_mrd        <= (mac[a_maddr] & ~a_mwe) | (a_mwd & a_mwe);
    end
  end

  // ---------------- instance B: fixed priority
  logic [1:0]      b_req, b_gnt, b_rvalid;
  logic [1:0]      b_we    = '0;
  logic [2*AW-1:0] b_addr  = '0;
  logic [2*DW-1:0] b_wdata = '0, b_wmask = '0;
  logic [DW-1:0]   b_rdata, b_mwe, b_mwd;
  logic [AW-1:0]   b_maddr;
  logic            b_en;

  sram_rr_arbiter #(.NumReq(2), .SramAw(AW), .SramDw(DW), .FixedPrio(1'b1)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
    .wdata_i(b_wdata), .wmask_i(b_wmask), .gnt_o(b_gnt), .rvalid_o(b_rvalid),
    .rdata_o(b_rdata), .mem_en_o(b_en), .mem_we_o(b_mwe), .mem_addr_o(b_maddr),
    .mem_wdata_o(b_mwd), .mem_rdata_i(32'h0BAD_F00D)
  );

  // ---------------- instance C: three requesters
  logic [2:0]      c_req, c_gnt, c_rvalid;
  logic [2:0]      c_we    = '0;
  logic [3*AW-1:0] c_addr  = '0;
  logic [3*DW-1:0] c_wdata = '0, c_wmask = '0;
  logic [DW-1:0]   c_rdata, c_mwe, c_mwd;
  logic [AW-1:0]   c_maddr;
  logic            c_en;

  sram_rr_arbiter #(.NumReq(3), .SramAw(AW), .SramDw(DW), .FixedPrio(1'b0)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(c_req), .we_i(c_we), .addr_i(c_addr),
    .wdata_i(c_wdata), .wmask_i(c_wmask), .gnt_o(c_gnt), .rvalid_o(c_rvalid),
    .rdata_o(c_rdata), .mem_en_o(c_en), .mem_we_o(c_mwe), .mem_addr_o(c_maddr),
    .mem_wdata_o(c_mwd), .mem_rdata_i(32'h5A5A_5A5A)
  );

  // ---------------- scoreboard for instance A
  typedef struct {
    logic [1:0]    rv;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t q[$];
  int   a_ptr = 0;

  function automatic int pick(input logic [3:0] req, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      if (req[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic set_a(input int r, input logic we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, input logic [DW-1:0] wm);
    a_req[r]             = 1'b1;
    a_we[r]              = we;
    a_addr[r*AW +: AW]   = ad;
    a_wdata[r*DW +: DW]  = wd;
    a_wmask[r*DW +: DW]  = wm;
  endtask

  task automatic idle_a();
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_wmask = '0;
  endtask

  // Called just after a posedge with inputs set; checks the access, then the return.
  task automatic a_step(input string tag);
    int            w;
    logic [1:0]    eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew, ed;
    exp_t          e;
    #1;
    w  = pick({2'b00, a_req}, a_ptr, 2);
    eg = (w >= 0) ? 2'(1 << w) : 2'b00;
    check({tag, " gnt"}, 64'(a_gnt), 64'(eg));
    check({tag, " en"}, 64'(a_en), 64'(w >= 0));
    if (w >= 0) begin
      ea = a_addr[w*AW +: AW];
      ed = a_wdata[w*DW +: DW];
      ew = a_we[w] ? a_wmask[w*DW +: DW] : '0;
      check({tag, " addr"}, 64'(a_maddr), 64'(ea));
      check({tag, " we"}, 64'(a_mwe), 64'(ew));
      check({tag, " wdata"}, 64'(a_mwd), 64'(ed));
      if (ew == '0) begin
        e.rv = eg;
        e.rd = ref_mem[ea];
      end else begin
        ref_mem[ea] = (ref_mem[ea] & ~ew) | (ed & ew);
        e.rv = '0;
        e.rd = '0;
      end
      a_ptr = (w + 1) % 2;
    end else begin
      check({tag, " idle we"}, 64'(a_mwe), 64'd0);
      e.rv = '0;
      e.rd = '0;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({tag, " rvalid"}, 64'(a_rvalid), 64'(e.rv));
    check({tag, " rdata"}, 64'(a_rdata), 64'(e.rd));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_ptr = 0;
  endtask

  logic [2:0] c_exp [3];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mac[i]     = {20'hA5A50, 12'(i)};
      ref_mem[i] = {20'hA5A50, 12'(i)};
    end
    mac[12'h010]     = 32'hDEAD_BEEF;
    ref_mem[12'h010] = 32'hDEAD_BEEF;
    idle_a();
    b_req = '0;
    c_req = '0;

    // Reset state, including requests asserted while in reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst rvalid", 64'(a_rvalid), 64'd0);
    check("rst rdata", 64'(a_rdata), 64'd0);
    a_req = 2'b11;
    #1;
    check("rst gnt", 64'(a_gnt), 64'd0);
    check("rst en", 64'(a_en), 64'd0);
    idle_a();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read of 0xDEADBEEF on requester 0
    set_a(0, 1'b0, 12'h010, '0, '0);
    a_step("t1 read");
    idle_a();
    a_step("t1 idle");

    // Both requesters held, pointer starting from reset
    do_reset();
    set_a(0, 1'b0, 12'h030, '0, '0);
    set_a(1, 1'b0, 12'h031, '0, '0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2 gnt seq", 64'(a_gnt), (k % 2 == 0) ? 64'd1 : 64'd2);
      #0 a_step("t2 rr");
    end
    idle_a();

    // Masked write on requester 1, then read back on requester 0
    set_a(1, 1'b1, 12'h0FF, 32'h1234_5678, 32'h0000_FFFF);
    a_step("t4 write");
    idle_a();
    set_a(0, 1'b0, 12'h0FF, '0, '0);
    a_step("t4 read");
    check("t4 low half", 64'(a_rdata), 64'(32'h0000_5678 | 32'hA5A5_0000));
    idle_a();

    // Zero write mask behaves as a read
    set_a(1, 1'b1, 12'h040, 32'hFFFF_FFFF, 32'h0);
    a_step("zero mask");
    idle_a();
    a_step("zero mask idle");

    // Fixed priority: requester 1 starves
    b_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fp gnt", 64'(b_gnt), 64'd1);
      @(posedge clk);
      #1;
      check("fp rvalid", 64'(b_rvalid), 64'd1);
      check("fp rdata", 64'(b_rdata), 64'h0BAD_F00D);
    end
    b_req = '0;

    // Three requesters: move pointer to 2, then all request
    c_req = 3'b010;
    #1;
    check("c3 pre gnt", 64'(c_gnt), 64'd2);
    @(posedge clk);
    #1;
    c_exp = '{3'b100, 3'b001, 3'b010};
    c_req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("c3 gnt", 64'(c_gnt), 64'(c_exp[k]));
      @(posedge clk);
      #1;
      check("c3 rvalid", 64'(c_rvalid), 64'(c_exp[k]));
      check("c3 rdata", 64'(c_rdata), 64'h5A5A_5A5A);
    end
    c_req = '0;
    #1;
    check("c3 idle gnt", 64'(c_gnt), 64'd0);
    @(posedge clk);
    #1;
    check("c3 idle rvalid", 64'(c_rvalid), 64'd0);

    // Read granted, reset sampled on the next edge: no return, pointer cleared
    set_a(0, 1'b0, 12'h020, '0, '0);
    #1;
    check("t5 gnt", 64'(a_gnt), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t5 rvalid", 64'(a_rvalid), 64'd0);
    check("t5 rdata", 64'(a_rdata), 64'd0);
    idle_a();
    rst_n = 1'b1;
    a_ptr = 0;
    set_a(0, 1'b0, 12'h021, '0, '0);
    set_a(1, 1'b0, 12'h022, '0, '0);
    #1;
    check("t5 ptr reset", 64'(a_gnt), 64'd1);
    a_step("t5 after");
    idle_a();
    a_step("t5 idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
